// File: rtl/tx_msg_arbiter_if.sv
// Handshake bundle between message clients, the arbiter and the UART Tx.
// master = arbiter side, slave = clients/transmitter side.
interface tx_msg_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int LEN_W = 5
);
    logic [NREQ-1:0]       req;
    logic [NREQ*LEN_W-1:0] req_len;
    logic                  transmit_ready;
    logic                  stop;
    logic [NREQ-1:0]       grant;
    logic                  tx_ctrl;
    logic [LEN_W-1:0]      byte_idx;
    logic [NREQ-1:0]       msg_sent;
    logic                  msg_abort;
    logic                  busy;

    modport master (
        input  req,
        input  req_len,
        input  transmit_ready,
        input  stop,
        output grant,
        output tx_ctrl,
        output byte_idx,
        output msg_sent,
        output msg_abort,
        output busy
    );

    modport slave (
        output req,
        output req_len,
        output transmit_ready,
        output stop,
        input  grant,
        input  tx_ctrl,
        input  byte_idx,
        input  msg_sent,
        input  msg_abort,
        input  busy
    );
endinterface

// File: rtl/tx_msg_arbiter.sv
// Shares one UART Tx among NREQ message requesters, byte by byte.
// TX_ARB_FIXED_PRIO_EN selects fixed lowest-index priority over round-robin.
module tx_msg_arbiter #(
    parameter int NREQ    = 4,
    parameter int LEN_W   = 5,
    parameter int MAX_LEN = 16
) (
    input logic              clk,
    input logic              nrst,
    tx_msg_arbiter_if.master bus
);
    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [LEN_W-1:0] MAXL = LEN_W'(MAX_LEN);
    localparam logic [PW-1:0] LAST_RST = PW'(NREQ - 1);

    typedef enum logic [2:0] {
        IDLE,
        SEND,
        WAIT_LOW,
        WAIT_HIGH,
        DONE,
        ABORT
    } state_t;

    state_t           state, state_d;
    logic [NREQ-1:0]  grant, grant_d;
    logic [LEN_W-1:0] len, len_d;
    logic [LEN_W-1:0] idx, idx_d;
    logic [PW-1:0]    last, last_d;

    logic             found;
    logic [PW-1:0]    pick;
    logic [LEN_W-1:0] raw_len;
    logic [LEN_W-1:0] pick_len;

`ifdef TX_ARB_FIXED_PRIO_EN
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (bus.req[k]) begin
                found = 1'b1;
                pick  = PW'(k);
            end
        end
    end
`else
    // Scan downward so the candidate nearest after last wins.
    always_comb begin
        int            j;
        logic [PW-1:0] cand;
        found = 1'b0;
        pick  = '0;
        j     = 0;
        cand  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            j    = (int'(last) + k) % NREQ;
            cand = PW'(j);
            if (bus.req[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end
`endif

    assign raw_len  = bus.req_len[pick*LEN_W +: LEN_W];
    assign pick_len = (raw_len > MAXL) ? MAXL : raw_len;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= IDLE;
            grant <= '0;
            len   <= '0;
            idx   <= '0;
            last  <= LAST_RST;
        end else begin
            state <= state_d;
            grant <= grant_d;
            len   <= len_d;
            idx   <= idx_d;
            last  <= last_d;
        end
    end

    always_comb begin
        state_d = state;
        grant_d = grant;
        len_d   = len;
        idx_d   = idx;
        last_d  = last;
        unique case (state)
            IDLE: begin
                if (found) begin
                    grant_d       = '0;
                    grant_d[pick] = 1'b1;
                    len_d         = pick_len;
                    idx_d         = '0;
                    last_d        = pick;
                    state_d = (pick_len == '0) ? DONE : SEND;
                end
            end
            SEND: begin
                if (bus.stop) begin
                    state_d = ABORT;
                end else if (bus.transmit_ready) begin
                    state_d = WAIT_LOW;
                end
            end
            WAIT_LOW: begin
                if (!bus.transmit_ready) begin
                    state_d = WAIT_HIGH;
                end
            end
            // A stop seen mid-byte is honoured only once the byte ends.
            WAIT_HIGH: begin
                if (bus.transmit_ready) begin
                    if (bus.stop) begin
                        state_d = ABORT;
                    end else if (idx == len - 1'b1) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx + 1'b1;
                        state_d = SEND;
                    end
                end
            end
            DONE: begin
                grant_d = '0;
                state_d = IDLE;
            end
            ABORT: begin
                grant_d = '0;
                idx_d   = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.grant     = grant;
    assign bus.byte_idx  = idx;
    assign bus.busy      = (state != IDLE);
    assign bus.msg_abort = (state == ABORT);
    assign bus.msg_sent  = (state == DONE) ? grant : '0;
    assign bus.tx_ctrl   = (state == SEND) & bus.transmit_ready
                         & ~bus.stop;
endmodule

// File: tb/tb_tx_msg_arbiter.sv
// Directed bench for tx_msg_arbiter with a small UART Tx handshake model.
// Expectations switch with TX_ARB_FIXED_PRIO_EN.
module tb_tx_msg_arbiter;
    localparam int NREQ  = 4;
    localparam int LEN_W = 5;

    logic clk;
    logic nrst;

    tx_msg_arbiter_if #(.NREQ(NREQ), .LEN_W(LEN_W)) bus ();

    tx_msg_arbiter #(
        .NREQ(NREQ),
        .LEN_W(LEN_W),
        .MAX_LEN(16)
    ) dut (
        .clk(clk),
        .nrst(nrst),
        .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    int pulses, idx_bad, msg_pulses, last_idx;
    int sent_cnt, abort_cnt, gcnt;
    logic [NREQ-1:0] sent_last;
    logic [NREQ-1:0] prev_grant;
    logic [NREQ-1:0] g_hist [8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Transmitter: after a start pulse, busy (ready low) for 2 cycles.
    initial begin
        bus.transmit_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (bus.tx_ctrl) begin
                @(posedge clk);
                #1 bus.transmit_ready = 1'b0;
                repeat (2) @(posedge clk);
                #1 bus.transmit_ready = 1'b1;
            end
        end
    end

    // Monitor: pulse/grant/completion bookkeeping at the falling edge.
    initial begin
        prev_grant = '0;
        msg_pulses = 0;
        forever begin
            @(negedge clk);
            if (bus.grant != '0 && prev_grant == '0) begin
                msg_pulses = 0;
                if (gcnt < 8) g_hist[gcnt] = bus.grant;
                gcnt++;
            end
            if (bus.tx_ctrl) begin
                if (int'(bus.byte_idx) != msg_pulses) idx_bad++;
                last_idx = int'(bus.byte_idx);
                msg_pulses++;
                pulses++;
            end
            if (bus.msg_sent != '0) begin
                sent_cnt++;
                sent_last = bus.msg_sent;
            end
            if (bus.msg_abort) abort_cnt++;
            prev_grant = bus.grant;
        end
    end

    task automatic check(input string tag,
                         input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        pulses    = 0;
        idx_bad   = 0;
        last_idx  = 0;
        sent_cnt  = 0;
        abort_cnt = 0;
        gcnt      = 0;
        sent_last = '0;
    endtask

    task automatic set_len(input int i, input int v);
        bus.req_len[i*LEN_W +: LEN_W] = LEN_W'(v);
    endtask

    task automatic pulse_reset();
        nrst = 1'b0;
        step();
        nrst = 1'b1;
        step();
    endtask

    task automatic wait_idle(input int budget, input string tag);
        int n;
        n = 0;
        while (bus.busy && n < budget) begin
            step();
            n++;
        end
        check(tag, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        logic [NREQ-1:0] exp_g [5];
        logic [NREQ-1:0] exp_next;
        int lens [2];
        int n;

`ifdef TX_ARB_FIXED_PRIO_EN
        exp_g    = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
        exp_next = 4'b0001;
`else
        exp_g    = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        exp_next = 4'b0100;
`endif
        lens = '{16, 31};

        nrst        = 1'b0;
        bus.req     = '0;
        bus.req_len = '0;
        bus.stop    = 1'b0;
        clear();
        repeat (3) step();

        check("rst_grant", 32'(bus.grant), 32'd0);
        check("rst_tx_ctrl", 32'(bus.tx_ctrl), 32'd0);
        check("rst_byte_idx", 32'(bus.byte_idx), 32'd0);
        check("rst_msg_sent", 32'(bus.msg_sent), 32'd0);
        check("rst_msg_abort", 32'(bus.msg_abort), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        nrst = 1'b1;
        step();

        // Single 3-byte message on requester 0
        set_len(0, 3);
        bus.req = 4'b0001;
        clear();
        step();
        check("t1_grant", 32'(bus.grant), 32'h1);
        check("t1_busy", 32'(bus.busy), 32'd1);
        check("t1_idx0", 32'(bus.byte_idx), 32'd0);
        bus.req = '0;
        wait_idle(200, "t1_idle");
        check("t1_pulses", 32'(pulses), 32'd3);
        check("t1_idxseq", 32'(idx_bad), 32'd0);
        check("t1_last_idx", 32'(last_idx), 32'd2);
        check("t1_sent_cnt", 32'(sent_cnt), 32'd1);
        check("t1_sent_val", 32'(sent_last), 32'h1);
        check("t1_abort", 32'(abort_cnt), 32'd0);

        // All requesting, 1 byte each: grant order
        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_len(i, 1);
        bus.req = 4'b1111;
        clear();
        n = 0;
        while (gcnt < 5 && n < 100) begin
            step();
            n++;
        end
        bus.req = '0;
        check("t2_gcnt", 32'(gcnt), 32'd5);
        wait_idle(100, "t2_idle");
        for (int i = 0; i < 5; i++)
            check($sformatf("t2_grant%0d", i),
                  32'(g_hist[i]), 32'(exp_g[i]));
        check("t2_pulses", 32'(pulses), 32'd5);
        check("t2_sent_cnt", 32'(sent_cnt), 32'd5);

        // Length clamp on requester 2
        for (int r = 0; r < 2; r++) begin
            set_len(2, lens[r]);
            bus.req = 4'b0100;
            clear();
            step();
            check($sformatf("t3_grant_%0d", lens[r]),
                  32'(bus.grant), 32'h4);
            bus.req = '0;
            wait_idle(300, "t3_idle");
            check($sformatf("t3_pulses_%0d", lens[r]),
                  32'(pulses), 32'd16);
            check($sformatf("t3_last_%0d", lens[r]),
                  32'(last_idx), 32'd15);
            check($sformatf("t3_idxseq_%0d", lens[r]),
                  32'(idx_bad), 32'd0);
            check($sformatf("t3_sent_%0d", lens[r]),
                  32'(sent_last), 32'h4);
        end

        // Zero-length message on requester 1
        set_len(1, 0);
        bus.req = 4'b0010;
        clear();
        step();
        check("t4_grant", 32'(bus.grant), 32'h2);
        check("t4_msg_sent", 32'(bus.msg_sent), 32'h2);
        check("t4_tx_ctrl", 32'(bus.tx_ctrl), 32'd0);
        check("t4_busy", 32'(bus.busy), 32'd1);
        bus.req = '0;
        step();
        check("t4_grant_clr", 32'(bus.grant), 32'd0);
        check("t4_sent_clr", 32'(bus.msg_sent), 32'd0);
        check("t4_busy_clr", 32'(bus.busy), 32'd0);
        check("t4_pulses", 32'(pulses), 32'd0);
        check("t4_sent_cnt", 32'(sent_cnt), 32'd1);

        // Stop during WAIT_HIGH of byte 2 of a 5-byte message
        pulse_reset();
        set_len(0, 5);
        set_len(2, 1);
        bus.req = 4'b0101;
        clear();
        step();
        check("t5_grant", 32'(bus.grant), 32'h1);
        n = 0;
        while (pulses < 3 && n < 100) begin
            step();
            n++;
        end
        step();
        check("t5_idx2", 32'(bus.byte_idx), 32'd2);
        bus.stop = 1'b1;
        n = 0;
        while (!bus.msg_abort && n < 50) begin
            step();
            n++;
        end
        check("t5_abort_seen", 32'(bus.msg_abort), 32'd1);
        check("t5_pulses", 32'(pulses), 32'd3);
        check("t5_no_sent", 32'(sent_cnt), 32'd0);
        bus.stop = 1'b0;
        step();
        check("t5_idle_busy", 32'(bus.busy), 32'd0);
        check("t5_idle_grant", 32'(bus.grant), 32'd0);
        check("t5_idle_idx", 32'(bus.byte_idx), 32'd0);
        step();
        check("t5_next_grant", 32'(bus.grant), 32'(exp_next));
        bus.req = '0;
        wait_idle(100, "t5_idle");
        check("t5_abort_cnt", 32'(abort_cnt), 32'd1);
        check("t5_sent_cnt", 32'(sent_cnt), 32'd1);
        check("t5_sent_val", 32'(sent_last), 32'(exp_next));

        // Reset asserted in WAIT_LOW
        set_len(0, 4);
        bus.req = 4'b0001;
        clear();
        step();
        bus.req = '0;
        n = 0;
        while (pulses < 1 && n < 20) begin
            step();
            n++;
        end
        check("t6_in_flight", 32'(bus.busy), 32'd1);
        nrst = 1'b0;
        #1;
        check("t6_grant", 32'(bus.grant), 32'd0);
        check("t6_tx_ctrl", 32'(bus.tx_ctrl), 32'd0);
        check("t6_byte_idx", 32'(bus.byte_idx), 32'd0);
        check("t6_busy", 32'(bus.busy), 32'd0);
        check("t6_msg_sent", 32'(bus.msg_sent), 32'd0);
        check("t6_msg_abort", 32'(bus.msg_abort), 32'd0);
        repeat (3) step();
        check("t6_no_sent", 32'(sent_cnt), 32'd0);
        check("t6_no_abort", 32'(abort_cnt), 32'd0);
        nrst = 1'b1;
        step();
        bus.req = 4'b0001;
        step();
        check("t6_regrant", 32'(bus.grant), 32'h1);
        bus.req = '0;
        wait_idle(100, "t6_idle");
        check("t6_sent_cnt", 32'(sent_cnt), 32'd1);
        check("t6_pulses", 32'(pulses), 32'd5);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end
endmodule

// File: doc/tx_msg_arbiter.md
Name: tx_msg_arbiter

Overview:
- Schedules a single shared UART transmit datapath among NREQ message requesters.
- Grants one requester at a time using round-robin arbitration, then sequences that requester's message byte by byte.
- Per byte: issues a tx_ctrl start pulse and tracks the transmitter's transmit_ready handshake until the byte completes.
- Sits between the message-buffer clients and the Tx external FSM/counter; drives byte_idx so the granted client's buffer presents the correct byte.

Parameters:
- NREQ, 4, number of requesters (2..8).
- LEN_W, 5, width of each per-requester length field.
- MAX_LEN, 16, maximum bytes per message; larger lengths clamp to MAX_LEN.

Ports:
- clk  input  1  system clock, rising-edge.
- nrst  input  1  asynchronous active-low reset.
- req  input  NREQ  level request per requester.
- req_len  input  NREQ*LEN_W  flattened byte counts; requester i uses bits [i*LEN_W +: LEN_W].
- transmit_ready  input  1  high when the transmitter is idle and can accept a byte.
- stop  input  1  abort request, sampled each cycle.
- grant  output  NREQ  one-hot grant, held for the whole message.
- tx_ctrl  output  1  one-cycle byte-start pulse to the transmitter.
- byte_idx  output  LEN_W  index of the current byte, 0-based.
- msg_sent  output  NREQ  one-cycle completion pulse on the granted bit.
- msg_abort  output  1  one-cycle pulse when a message is abandoned via stop.
- busy  output  1  high in every state except IDLE.

Behaviour:
- Reset (nrst=0, asynchronous):
  - state=IDLE; grant, byte_idx, msg_sent, msg_abort, busy all 0; tx_ctrl=0.
  - Round-robin pointer last=NREQ-1, so requester 0 wins first.
- States: IDLE, SEND, WAIT_LOW, WAIT_HIGH, DONE, ABORT.
- IDLE:
  - If req!=0, pick the first set bit searching from last+1, wrapping.
  - Next cycle: grant registered; len latched as min(req_len[i], MAX_LEN); byte_idx=0; last=i.
  - Next state is SEND, or DONE if the latched len=0 (no tx_ctrl is issued).
  - Requester latency: 1 cycle from req to grant.
- SEND:
  - tx_ctrl = (state==SEND) & transmit_ready & ~stop (combinational).
  - On tx_ctrl, go to WAIT_LOW.
  - If stop=1, go to ABORT with no pulse.
  - If transmit_ready=0, hold.
- WAIT_LOW: wait for transmit_ready=0 (transmitter accepted the byte), then go to WAIT_HIGH.
- WAIT_HIGH: wait for transmit_ready=1 (byte complete), then:
  - stop=1: go to ABORT.
  - else byte_idx==len-1: go to DONE.
  - else byte_idx+=1 and go to SEND.
- DONE: msg_sent[i]=1 for one cycle, grant cleared, go to IDLE.
- ABORT: msg_abort=1 for one cycle, grant cleared, byte_idx=0, go to IDLE.
- stop in WAIT_LOW/WAIT_HIGH: the in-flight byte is never cut off; the abort takes effect after WAIT_HIGH completes.
- req and req_len changes after grant are ignored until the next arbitration. Deasserting the granted req does not cancel the message.
- busy=1 in every state except IDLE.
- New arbitration happens only in IDLE. The minimum gap between consecutive messages is 1 IDLE cycle.
- Only one bit of grant/msg_sent is ever high; grant is 0 in IDLE.
- nrst asserted mid-message returns everything to reset values immediately. No msg_sent or msg_abort pulse is produced.

Optional Feature:
- Macro: TX_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; the lowest-index set req always wins, and the pointer is unused.
- Undefined: round-robin as described in Behaviour.

Test Plan:
- Reset then req=4'b0001, len0=3, transmit_ready toggling 1->0 (2 cycles)->1 per byte -> exactly 3 tx_ctrl pulses, byte_idx 0,1,2, then msg_sent=4'b0001 once, busy falls.
- req=4'b1111 held, all len=1 -> grant order 0001, 0010, 0100, 1000, 0001; with TX_ARB_FIXED_PRIO_EN defined, 0001 every time.
- req_len=16 and then 31 on requester 2 -> 16 tx_ctrl pulses each time, final byte_idx=15.
- len=0 on requester 1 -> grant for 1 cycle, no tx_ctrl, msg_sent=4'b0010.
- stop=1 during WAIT_HIGH of byte 2 of a 5-byte message -> byte 2 completes, msg_abort pulses, no msg_sent, next grant goes to the next requester in round-robin order.
- nrst=0 in WAIT_LOW -> all outputs 0 immediately; after release, req on 0 granted in 1 cycle.
